// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - fetch/data arbiter for a single-port synchronous-read unified memory
module riscv_mem_arbiter #(
   parameter int XLEN          = 32,
   parameter int MEM_ADDR_BIT  = 12,
   parameter int MAX_DM_STREAK = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic                    i_arb_if_req,
   input  logic [XLEN-1:0]         i_arb_if_addr,
   input  logic                    i_arb_if_kill,
   output logic                    o_arb_if_gnt,
   output logic                    o_arb_if_rvalid,
   output logic [XLEN-1:0]         o_arb_if_rdata,
   input  logic                    i_arb_dm_req,
   input  logic                    i_arb_dm_we,
   input  logic [XLEN-1:0]         i_arb_dm_addr,
   input  logic [3:0]              i_arb_dm_byte_sel,
   input  logic [XLEN-1:0]         i_arb_dm_wdata,
   output logic                    o_arb_dm_gnt,
   output logic                    o_arb_dm_rvalid,
   output logic [XLEN-1:0]         o_arb_dm_rdata,
   output logic                    o_arb_mem_en,
   output logic                    o_arb_mem_we,
   output logic [MEM_ADDR_BIT-3:0] o_arb_mem_addr,
   output logic [3:0]              o_arb_mem_byte_sel,
   output logic [XLEN-1:0]         o_arb_mem_wdata,
   input  logic [XLEN-1:0]         i_arb_mem_rdata
);

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_DM   = 2'd2
   } owner_e;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

   owner_e     owner_q, owner_d;
   logic [3:0] streak_q, streak_d;
   logic       if_gnt, dm_gnt;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         owner_q  <= OWN_NONE;
         streak_q <= '0;
      end else begin
         owner_q  <= owner_d;
         streak_q <= streak_d;
      end
   end

   // Data wins unless fetch has already lost STREAK_MAX conflicting cycles in a row.
   always_comb begin
      if_gnt   = 1'b0;
      dm_gnt   = 1'b0;
      owner_d  = OWN_NONE;
      streak_d = '0;
      if (i_arb_dm_req && !(i_arb_if_req && streak_q == STREAK_MAX)) begin
         dm_gnt = 1'b1;
      end else if (i_arb_if_req) begin
         if_gnt = 1'b1;
      end
      if (if_gnt) begin
         owner_d = OWN_IF;
      end else if (dm_gnt && !i_arb_dm_we) begin
         owner_d = OWN_DM;
      end
      if (dm_gnt && i_arb_if_req) begin
         streak_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
      end
   end

   assign o_arb_if_gnt       = if_gnt;
   assign o_arb_dm_gnt       = dm_gnt;
   assign o_arb_mem_en       = if_gnt | dm_gnt;
   assign o_arb_mem_we       = dm_gnt & i_arb_dm_we;
   assign o_arb_mem_addr     = if_gnt ? i_arb_if_addr[MEM_ADDR_BIT-1:2]
                                      : i_arb_dm_addr[MEM_ADDR_BIT-1:2];
   assign o_arb_mem_byte_sel = o_arb_mem_we ? i_arb_dm_byte_sel : 4'hF;
   assign o_arb_mem_wdata    = i_arb_dm_wdata;

   // A killed fetch response is simply dropped; the owner register still retires it.
   assign o_arb_if_rvalid    = (owner_q == OWN_IF) & ~i_arb_if_kill;
   assign o_arb_dm_rvalid    = (owner_q == OWN_DM);
   assign o_arb_if_rdata     = i_arb_mem_rdata;
   assign o_arb_dm_rdata     = i_arb_mem_rdata;

   logic unused_addr_bits;
   assign unused_addr_bits = &{1'b0, i_arb_if_addr[XLEN-1:MEM_ADDR_BIT], i_arb_if_addr[1:0],
                               i_arb_dm_addr[XLEN-1:MEM_ADDR_BIT], i_arb_dm_addr[1:0]};

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - randomized scoreboard bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;
   localparam int XLEN  = 32;
   localparam int MAB   = 12;
   localparam int MAXS  = 4;
   localparam int WORDS = 1 << (MAB - 2);

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             if_req = 1'b0, if_kill = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
   logic [XLEN-1:0]  if_addr = '0, dm_addr = '0, dm_wdata = '0;
   logic [3:0]       dm_bsel = '0;
   logic             if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_en, mem_we;
   logic [XLEN-1:0]  if_rdata, dm_rdata, mem_wdata, ram_rdata;
   logic [MAB-3:0]   mem_addr;
   logic [3:0]       mem_bsel;

   always #5 clk = ~clk;

   riscv_mem_arbiter #(.XLEN(XLEN), .MEM_ADDR_BIT(MAB), .MAX_DM_STREAK(MAXS)) dut (
      .i_clk(clk), .i_rstn(rst_n),
      .i_arb_if_req(if_req), .i_arb_if_addr(if_addr), .i_arb_if_kill(if_kill),
      .o_arb_if_gnt(if_gnt), .o_arb_if_rvalid(if_rvalid), .o_arb_if_rdata(if_rdata),
      .i_arb_dm_req(dm_req), .i_arb_dm_we(dm_we), .i_arb_dm_addr(dm_addr),
      .i_arb_dm_byte_sel(dm_bsel), .i_arb_dm_wdata(dm_wdata),
      .o_arb_dm_gnt(dm_gnt), .o_arb_dm_rvalid(dm_rvalid), .o_arb_dm_rdata(dm_rdata),
      .o_arb_mem_en(mem_en), .o_arb_mem_we(mem_we), .o_arb_mem_addr(mem_addr),
      .o_arb_mem_byte_sel(mem_bsel), .o_arb_mem_wdata(mem_wdata),
      .i_arb_mem_rdata(ram_rdata)
   );

   // Unified memory the arbiter drives: single port, synchronous read.
   logic [31:0] ram [WORDS];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++)
               if (mem_bsel[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         end else begin
            ram_rdata <= ram[mem_addr];
         end
      end
   end

   typedef struct {
      int          cyc;
      logic [31:0] data;
   } resp_t;

   resp_t       if_q[$];
   resp_t       dm_q[$];
   resp_t       rif, rdm;
   logic [31:0] ref_mem [WORDS];
   int          n_checks = 0;
   int          n_fail = 0;
   int          cur_cyc = 0;
   int          lost = 0;
   bit          mon_en = 1'b0;
   bit          pend_if = 1'b0, pend_dm = 1'b0;
   logic [31:0] pend_if_data, pend_dm_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cur_cyc, act, exp);
      end
   endtask

   // Monitor: every presented rvalid must match the oldest expected response of that cycle.
   always @(negedge clk) begin
      if (mon_en) begin
         #2;
         if (if_rvalid) begin
            if (if_q.size() == 0 || if_q[0].cyc != cur_cyc) begin
               n_checks++; n_fail++;
               $display("FAIL if_rvalid_unexpected cycle %0d: got 1 expected 0", cur_cyc);
            end else begin
               rif = if_q.pop_front();
               check("if_rdata", if_rdata, rif.data);
            end
         end else if (if_q.size() != 0 && if_q[0].cyc == cur_cyc) begin
            n_checks++; n_fail++;
            $display("FAIL if_rvalid_missing cycle %0d: got 0 expected 1", cur_cyc);
            rif = if_q.pop_front();
         end
         if (dm_rvalid) begin
            if (dm_q.size() == 0 || dm_q[0].cyc != cur_cyc) begin
               n_checks++; n_fail++;
               $display("FAIL dm_rvalid_unexpected cycle %0d: got 1 expected 0", cur_cyc);
            end else begin
               rdm = dm_q.pop_front();
               check("dm_rdata", dm_rdata, rdm.data);
            end
         end else if (dm_q.size() != 0 && dm_q[0].cyc == cur_cyc) begin
            n_checks++; n_fail++;
            $display("FAIL dm_rvalid_missing cycle %0d: got 0 expected 1", cur_cyc);
            rdm = dm_q.pop_front();
         end
      end
   end

   // One clock of stimulus; the reference model predicts grants, command and responses.
   task automatic drive_cycle(input bit ifr, input logic [31:0] ia, input bit kill,
                              input bit dr, input bit dwe, input logic [31:0] da,
                              input logic [3:0] bs, input logic [31:0] wd,
                              output bit g_if, output bit g_dm);
      bit         e_if, e_dm;
      logic [9:0] wa;
      @(negedge clk);
      cur_cyc++;
      if_req = ifr; if_addr = ia; if_kill = kill;
      dm_req = dr; dm_we = dwe; dm_addr = da; dm_bsel = bs; dm_wdata = wd;
      if (pend_if && !kill) if_q.push_back('{cur_cyc, pend_if_data});
      if (pend_dm) dm_q.push_back('{cur_cyc, pend_dm_data});
      e_if = ifr && (!dr || lost == MAXS);
      e_dm = dr && !e_if;
      #1;
      check("if_gnt", 32'(if_gnt), 32'(e_if));
      check("dm_gnt", 32'(dm_gnt), 32'(e_dm));
      check("mem_en", 32'(mem_en), 32'(e_if | e_dm));
      pend_if = e_if;
      pend_dm = e_dm && !dwe;
      if (e_if) begin
         wa = ia[11:2];
         check("if_mem_addr", 32'(mem_addr), 32'(wa));
         check("if_mem_we", 32'(mem_we), 32'd0);
         pend_if_data = ref_mem[wa];
      end
      if (e_dm) begin
         wa = da[11:2];
         check("dm_mem_addr", 32'(mem_addr), 32'(wa));
         check("dm_mem_we", 32'(mem_we), 32'(dwe));
         check("dm_byte_sel", 32'(mem_bsel), dwe ? 32'(bs) : 32'hF);
         if (dwe) begin
            check("dm_wdata", mem_wdata, wd);
            for (int b = 0; b < 4; b++)
               if (bs[b]) ref_mem[wa][8*b +: 8] = wd[8*b +: 8];
         end else begin
            pend_dm_data = ref_mem[wa];
         end
      end
      lost = (!ifr || e_if) ? 0 : lost + 1;
      g_if = e_if;
      g_dm = e_dm;
   endtask

   bit          gi, gd;
   bit [5:0]    gi_hist, gd_hist;
   bit          r_ifr, r_dr, r_dwe, r_kill;
   logic [31:0] r_ia, r_da, r_wd;
   logic [3:0]  r_bs;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < WORDS; i++) begin
         ram[i]     = (i == 8) ? 32'h0 : $urandom;
         ref_mem[i] = ram[i];
      end
      repeat (3) @(negedge clk);
      check("reset_if_rvalid", 32'(if_rvalid), 32'd0);
      check("reset_dm_rvalid", 32'(dm_rvalid), 32'd0);
      rst_n = 1'b1;

      // Reset during an in-flight data read drops the response.
      @(negedge clk);
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
      @(posedge clk); #1;
      dm_req = 1'b0;
      check("inflight_dm_rvalid", 32'(dm_rvalid), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_reset_dm_rvalid", 32'(dm_rvalid), 32'd0);
      check("mid_reset_if_rvalid", 32'(if_rvalid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk); #2;
         check("post_reset_dm_rvalid", 32'(dm_rvalid), 32'd0);
         check("post_reset_if_rvalid", 32'(if_rvalid), 32'd0);
      end

      mon_en = 1'b1;
      // Uncontended fetch, then data write and read-back of a zeroed word.
      drive_cycle(1, 32'h10, 0, 0, 0, 0, 4'h0, 0, gi, gd);
      drive_cycle(0, 0, 0, 1, 1, 32'h20, 4'b0011, 32'hDEAD_BEEF, gi, gd);
      drive_cycle(0, 0, 0, 1, 0, 32'h20, 4'h0, 0, gi, gd);
      drive_cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, gi, gd);
      check("write_merge_model", ref_mem[8], 32'h0000_BEEF);

      // Both ports held: four data grants, then fetch, then data again.
      for (int i = 0; i < 6; i++) begin
         drive_cycle(1, 32'h100, 0, 1, 0, 32'h44, 4'h0, 0, gi, gd);
         gi_hist[i] = gi;
         gd_hist[i] = gd;
      end
      check("contention_if_pattern", 32'(gi_hist), 32'b010000);
      check("contention_dm_pattern", 32'(gd_hist), 32'b101111);
      drive_cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, gi, gd);

      // Killed fetch response alongside a data read granted in the same cycle.
      drive_cycle(1, 32'h18, 0, 0, 0, 0, 4'h0, 0, gi, gd);
      drive_cycle(0, 0, 1, 1, 0, 32'h80, 4'h0, 0, gi, gd);
      drive_cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, gi, gd);

      // Back-to-back alternating data read / fetch.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) drive_cycle(0, 0, 0, 1, 0, 32'(i * 4 + 12), 4'h0, 0, gi, gd);
         else            drive_cycle(1, 32'(i * 8), 0, 0, 0, 0, 4'h0, 0, gi, gd);
      end

      // Random traffic; ungranted requests hold their payload.
      r_ifr = 0; r_dr = 0;
      for (int i = 0; i < 400; i++) begin
         if (!r_ifr && $urandom_range(0, 2) != 0) begin
            r_ifr = 1;
            r_ia  = 32'($urandom_range(0, 63)) << 2;
         end
         if (!r_dr && $urandom_range(0, 2) != 0) begin
            r_dr  = 1;
            r_dwe = ($urandom_range(0, 2) == 0);
            r_da  = 32'($urandom_range(0, 63)) << 2;
            r_bs  = 4'($urandom_range(0, 15));
            r_wd  = $urandom;
         end
         r_kill = ($urandom_range(0, 7) == 0);
         drive_cycle(r_ifr, r_ia, r_kill, r_dr, r_dwe, r_da, r_bs, r_wd, gi, gd);
         if (gi) r_ifr = 0;
         if (gd) r_dr = 0;
      end

      repeat (3) drive_cycle(0, 0, 0, 0, 0, 0, 4'h0, 0, gi, gd);
      @(negedge clk); #3;
      check("if_queue_drained", 32'(if_q.size()), 32'd0);
      check("dm_queue_drained", 32'(dm_q.size()), 32'd0);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
